// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage: FSM state encoding,
// lane geometry and a helper that extracts one word lane from a vector.
package mem_pkg;
   localparam int MEM_DATA_W = 128;
   localparam int MEM_WORD_W = 32;
   localparam int MEM_LANES  = MEM_DATA_W / MEM_WORD_W;
   localparam int LANE_IDX_W = $clog2(MEM_LANES);

   typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_e;

   function automatic logic [MEM_WORD_W-1:0] lane_slice(
      input logic [MEM_DATA_W-1:0] vec,
      input logic [LANE_IDX_W-1:0] k
   );
      return vec[k*MEM_WORD_W +: MEM_WORD_W];
   endfunction
endpackage

// File: rtl/vec_lane_buf.sv
// LANES x WORD_W lane register: bulk-loaded with store data, written one
// lane at a time during load assembly, read back one lane per beat.
module vec_lane_buf
   import mem_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_en,
   input  logic [MEM_DATA_W-1:0] load_data,
   input  logic                  wr_en,
   input  logic [LANE_IDX_W-1:0] wr_lane,
   input  logic [MEM_WORD_W-1:0] wr_data,
   input  logic [LANE_IDX_W-1:0] rd_lane,
   output logic [MEM_WORD_W-1:0] rd_data,
   output logic [MEM_DATA_W-1:0] vec_out
);
   logic [MEM_WORD_W-1:0] lane_q [MEM_LANES];
   logic [MEM_WORD_W-1:0] lane_d [MEM_LANES];

   always_comb begin
      for (int i = 0; i < MEM_LANES; i++) begin
         lane_d[i] = lane_q[i];
         if (load_en) begin
            lane_d[i] = lane_slice(load_data, LANE_IDX_W'(i));
         end else if (wr_en && (wr_lane == LANE_IDX_W'(i))) begin
            lane_d[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < MEM_LANES; i++) begin
         if (!rst) lane_q[i] <= '0;
         else      lane_q[i] <= lane_d[i];
      end
   end

   assign rd_data = lane_q[rd_lane];

   genvar gi;
   generate
      for (gi = 0; gi < MEM_LANES; gi++) begin : g_vec
         assign vec_out[gi*MEM_WORD_W +: MEM_WORD_W] = lane_q[gi];
      end
   endgenerate
endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: splits scalar/vector loads and stores into word beats,
// stalls upstream while busy and registers the write-back bundle.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int WORD_W = MEM_WORD_W,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRd2,
   input  logic              MemWr2,
   input  logic              RegWr2,
   input  logic              VF2,
   input  logic [3:0]        R_V_dest2,
   input  logic [DATA_W-1:0] ALURES2,
   input  logic [DATA_W-1:0] StData2,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              Stall,
   output logic              VF3,
   output logic [3:0]        R_V_dest3,
   output logic [DATA_W-1:0] ResRV,
   output logic              RegWr3
);
   localparam int LANES = DATA_W / WORD_W;

   state_e                state_q, state_d;
   logic [LANE_IDX_W-1:0] beat_q, beat_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic                  vf_q, vf_d;
   logic [3:0]            dest_q, dest_d;
   logic                  store_q, store_d;
   logic [DATA_W-1:0]     res_q, res_d;
   logic                  vf3_q, vf3_d;
   logic [3:0]            dest3_q, dest3_d;
   logic                  regwr3_q, regwr3_d;

   logic                  mem_op;
   logic                  is_last;
   logic [LANE_IDX_W-1:0] last_beat;
   logic                  buf_load, buf_wr;
   logic [WORD_W-1:0]     buf_rd;
   logic [DATA_W-1:0]     buf_vec;
   logic [DATA_W-1:0]     assembled;

   vec_lane_buf u_buf (
      .clk       (clk),
      .rst       (rst),
      .load_en   (buf_load),
      .load_data (StData2),
      .wr_en     (buf_wr),
      .wr_lane   (beat_q - LANE_IDX_W'(1)),
      .wr_data   (mem_rdata),
      .rd_lane   (beat_q),
      .rd_data   (buf_rd),
      .vec_out   (buf_vec)
   );

   assign mem_op    = MemRd2 | MemWr2;
   assign last_beat = vf_q ? LANE_IDX_W'(LANES-1) : '0;
   assign is_last   = (beat_q == last_beat);
   // The final load word is still on mem_rdata in RDWAIT, so it bypasses the buffer.
   assign assembled = vf_q ? {mem_rdata, buf_vec[DATA_W-WORD_W-1:0]} : DATA_W'(mem_rdata);

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      base_d   = base_q;
      vf_d     = vf_q;
      dest_d   = dest_q;
      store_d  = store_q;
      res_d    = res_q;
      vf3_d    = vf3_q;
      dest3_d  = dest3_q;
      regwr3_d = regwr3_q;
      buf_load = 1'b0;
      buf_wr   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               state_d  = ACCESS;
               beat_d   = '0;
               base_d   = ALURES2[ADDR_W-1:0];
               vf_d     = VF2;
               dest_d   = R_V_dest2;
               store_d  = MemWr2;
               buf_load = 1'b1;
            end else begin
               res_d    = ALURES2;
               vf3_d    = VF2;
               dest3_d  = R_V_dest2;
               regwr3_d = RegWr2;
            end
         end
         ACCESS: begin
            buf_wr = !store_q && (beat_q != '0);
            if (!is_last) begin
               beat_d = beat_q + LANE_IDX_W'(1);
            end else if (store_q) begin
               state_d  = IDLE;
               res_d    = '0;
               regwr3_d = 1'b0;
               vf3_d    = vf_q;
               dest3_d  = dest_q;
            end else begin
               state_d = RDWAIT;
            end
         end
         RDWAIT: begin
            state_d  = IDLE;
            res_d    = assembled;
            regwr3_d = 1'b1;
            vf3_d    = vf_q;
            dest3_d  = dest_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         base_q   <= '0;
         vf_q     <= 1'b0;
         dest_q   <= '0;
         store_q  <= 1'b0;
         res_q    <= '0;
         vf3_q    <= 1'b0;
         dest3_q  <= '0;
         regwr3_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         base_q   <= base_d;
         vf_q     <= vf_d;
         dest_q   <= dest_d;
         store_q  <= store_d;
         res_q    <= res_d;
         vf3_q    <= vf3_d;
         dest3_q  <= dest3_d;
         regwr3_q <= regwr3_d;
      end
   end

   assign Stall     = rst && (((state_q == IDLE) && mem_op) ||
                              ((state_q == ACCESS) && !(store_q && is_last)));
   assign mem_we    = rst && (state_q == ACCESS) && store_q;
   assign mem_addr  = (state_q == ACCESS) ? base_q + ADDR_W'(beat_q) : '0;
   assign mem_wdata = ((state_q == ACCESS) && store_q) ? buf_rd : '0;
   assign VF3       = vf3_q;
   assign R_V_dest3 = dest3_q;
   assign ResRV     = res_q;
   assign RegWr3    = regwr3_q;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the vector ASIP pipeline; sits downstream of execute_module and consumes its ALURES/VF/R_V_dest outputs.
- Converts scalar and 128-bit vector loads/stores into 32-bit word beats on the data-memory port.
- Produces the registered write-back bundle (VF3, R_V_dest3, ResRV) that execute_module takes back as forwarding input.
- Stalls the front of the pipeline while a multi-beat access is in flight.

Parameters:
- DATA_W, 128, vector/result width
- WORD_W, 32, data-memory word width
- ADDR_W, 32, word address width; LANES = DATA_W/WORD_W = 4 (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- MemRd2  in  1  load request from EX/MEM register
- MemWr2  in  1  store request
- RegWr2  in  1  op writes a register
- VF2  in  1  1 = vector op (LANES beats), 0 = scalar (1 beat)
- R_V_dest2  in  4  destination register index
- ALURES2  in  DATA_W  ALU result; bits [ADDR_W-1:0] are the word address for memory ops
- StData2  in  DATA_W  store data
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  WORD_W  write data
- mem_we  out  1  write strobe
- mem_rdata  in  WORD_W  read data, valid one cycle after the address
- Stall  out  1  hold upstream registers
- VF3  out  1  write-back vector flag
- R_V_dest3  out  4  write-back destination
- ResRV  out  DATA_W  write-back data
- RegWr3  out  1  write-back enable

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, beat counter 0, all outputs 0; Stall forced 0 while rst=0. Reset mid-access aborts it; no further mem_we.
- N = LANES if VF2 else 1. Lane k = bits [32k+31:32k]; lane 0 goes to the lowest address.
- Non-memory op (MemRd2=MemWr2=0): pass-through. Next edge: ResRV=ALURES2, VF3=VF2, R_V_dest3=R_V_dest2, RegWr3=RegWr2. Stall=0.
- MemRd2 and MemWr2 both set: treated as a store; no read occurs.
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE: when a memory op is present at cycle T, Stall=1 combinationally. Base address, store data, VF2, R_V_dest2 and the op type are captured at the T edge. Go to ACCESS with beat=0.
- ACCESS: beat k occupies cycle T+1+k. mem_addr = base+k, wrapping mod 2^ADDR_W. For stores, mem_we=1 and mem_wdata = lane k. For loads, mem_we=0 and mem_rdata is captured into lane k one cycle later.
- Store: last beat is cycle T+N. Stall=0 in that cycle. On its edge: RegWr3=0, ResRV=0, VF3 and R_V_dest3 from the captured values. Return to IDLE.
- Load: after the last beat, go to RDWAIT (cycle T+N+1) and capture the final word. Stall=0 in RDWAIT. On its edge: ResRV = assembled data (scalar result zero-extended to DATA_W), RegWr3=1, VF3/R_V_dest3 from the captured values. Return to IDLE.
- Stall duration: N cycles for stores, N+1 cycles for loads.
- Write-back outputs hold their value except on the completion edge or a pass-through edge. An op arriving in the cycle after completion is accepted with no bubble.
- mem_we=0 in IDLE and RDWAIT. mem_addr and mem_wdata are don't-care when not in ACCESS; drive 0.

Decomposition:
- Shared package mem_pkg: state enum (IDLE, ACCESS, RDWAIT), LANES constant, lane-slice helper function.
- One natural sub-module: vec_lane_buf. It is a LANES x WORD_W register with a write-lane port and a read-lane mux, and it is used for both store-data lane selection and load assembly.

Test Plan:
- Reset: rst=0 for 2 edges with MemWr2=1 → Stall=0, mem_we=0, ResRV=0, RegWr3=0 throughout.
- Pass-through: ALURES2=128'hA, RegWr2=1, R_V_dest2=4, VF2=0 → next edge ResRV=128'hA, RegWr3=1, R_V_dest3=4, Stall never high.
- Vector store: VF2=1, MemWr2=1, ALURES2=32'h10, StData2=128'h4444_4444_3333_3333_2222_2222_1111_1111 → mem_we=1 for 4 cycles at addresses 10,11,12,13 with data 1111_1111..4444_4444. Stall high 4 cycles; RegWr3=0.
- Vector load: memory[20..23]={A,B,C,D}, VF2=1, MemRd2=1, ALURES2=32'h20 → Stall high 5 cycles, then ResRV=128'h0000000D_0000000C_0000000B_0000000A, RegWr3=1, VF3=1.
- Scalar load with address wrap, then back-to-back ops: vector store at ALURES2=32'hFFFF_FFFE → addresses FFFF_FFFE, FFFF_FFFF, 0, 1. A scalar load of memory[5]=32'h77 presented on the completion cycle → accepted next cycle, ResRV=128'h77 two cycles later.
- Reset mid-access: vector store, rst=0 after beat 1 → mem_we low from the next cycle, state IDLE, no beat 2 write.
